axil_reg_if_nport: RTL and testbench
====================================

// Module: axil_reg_if_nport
// PURPOSE
//  AXI-Lite slave that fans one control-plane address window out to NUM_PORTS independent register
//  channels, each with its own wr/rd enable and ack. Next generation of the single-port register bridge:
//  address decode, per-port enables, DECERR for unmapped addresses, SLVERR on timeout.
//  Sits between the control interconnect and the UDP/MAC/IP register files.
// PARAMETERS
//  DATA_WIDTH       32              AXI-Lite and register data width (bits), multiple of 8
//  ADDR_WIDTH       16              AXI-Lite address width (bits)
//  STRB_WIDTH       DATA_WIDTH/8    write strobe width
//  NUM_PORTS        4               number of register channels, 1..16
//  PORT_ADDR_WIDTH  12              byte-address bits per port window; port = addr[PORT_ADDR_WIDTH +: SELW]
//  TIMEOUT          16              cycles without wait/ack before SLVERR; 0 disables timeout
//  SELW = max(1,$clog2(NUM_PORTS)); ADDR_WIDTH >= PORT_ADDR_WIDTH+SELW
// PORTS
//  clk               in   1                    clock, all logic on rising edge
//  rst               in   1                    synchronous reset, active high
//  s_axil_aw*/w*/b*  -    std AXI-Lite         awaddr[ADDR_WIDTH],awprot[3],awvalid,awready,wdata,wstrb,wvalid,wready,bresp[2],bvalid,bready
//  s_axil_ar*/r*     -    std AXI-Lite         araddr[ADDR_WIDTH],arprot[3],arvalid,arready,rdata,rresp[2],rvalid,rready
//  reg_wr_addr       out  PORT_ADDR_WIDTH      port-local write byte address (shared by all ports)
//  reg_wr_data       out  DATA_WIDTH           write data (shared)
//  reg_wr_strb       out  STRB_WIDTH           write strobes (shared)
//  reg_wr_en         out  NUM_PORTS            one-hot write enable, bit p = port p
//  reg_wr_wait       in   NUM_PORTS            port p requests more time (restarts timeout)
//  reg_wr_ack        in   NUM_PORTS            port p completed write
//  reg_rd_addr       out  PORT_ADDR_WIDTH      port-local read byte address (shared)
//  reg_rd_en         out  NUM_PORTS            one-hot read enable
//  reg_rd_data       in   NUM_PORTS*DATA_WIDTH port p data at [p*DATA_WIDTH +: DATA_WIDTH], valid with ack
//  reg_rd_wait       in   NUM_PORTS            port p read wait
//  reg_rd_ack        in   NUM_PORTS            port p read completion
// BEHAVIOUR
//  - Reset: all outputs 0 (readies, bvalid, rvalid, bresp, rresp, rdata, reg_*_en, reg_*_addr/data/strb).
//    Reset mid-transaction drops it: enables and valids low on next edge, no response issued.
//  - Write and read paths are independent FSMs; each has one transaction in flight; both may run at once.
//  - Write FSM IDLE->ACCESS->RESP->IDLE. IDLE: awready=wready=1 only when awvalid&&wvalid (both accepted
//    same cycle; never one without the other). Capture addr/data/strb; decode port p.
//  - Decode: p >= NUM_PORTS or any addr bit above PORT_ADDR_WIDTH+SELW set -> unmapped: skip ACCESS,
//    go RESP with bresp=DECERR(2'b11), no enable pulse.
//  - ACCESS: reg_wr_en[p]=1 every cycle in state (starts cycle after handshake). Only bit p of ack/wait
//    examined. ack[p] -> RESP, bresp=OKAY. Else wait[p] -> counter cleared. Else counter+1; counter
//    reaching TIMEOUT-1 (TIMEOUT>0) -> RESP, bresp=SLVERR(2'b10). ack and wait together: ack wins.
//  - RESP: bvalid=1, enables 0; bvalid&&bready -> IDLE; new AW/W not accepted before following cycle.
//  - Read FSM identical with ar*/r*: rdata latched from port p slice on ack; rdata=0 for DECERR/SLVERR.
//  - Min latency: handshake cycle N, en at N+1, ack at N+1 -> bvalid/rvalid at N+2.
//  - awprot/arprot ignored. Timeout counter width $clog2(TIMEOUT+1), reset to 0 on entry to ACCESS.
// TESTING
//  - Write 0x1004 data 0xA5A5_0001 strb 0xF, port1 acks same cycle -> reg_wr_en=4'b0010 one cycle,
//    reg_wr_addr=0x004, bresp=OKAY at handshake+2.
//  - Read 0x3010, port3 acks 3 cycles later with 0xDEAD_BEEF -> reg_rd_en=4'b1000 3 cycles,
//    rdata=0xDEAD_BEEF, rresp=OKAY.
//  - NUM_PORTS=3, write 0x3000 -> no reg_wr_en, bresp=DECERR; read 0x8000 -> rresp=DECERR, rdata=0.
//  - TIMEOUT=16, read port0, no ack/wait -> rresp=SLVERR, rdata=0, rd_en high exactly 16 cycles;
//    repeat with wait pulse every 10 cycles then ack at 40 -> OKAY.
//  - Concurrent write port0 and read port2, bready/rready low 5 cycles -> valids held, fields stable;
//    other ports' acks ignored.
//  - rst asserted while reg_wr_en high -> en, bvalid 0 next cycle; next write completes OKAY.

Source files
------------

// File: rtl/axil_reg_if_nport.sv
// AXI-Lite slave fanning one address window out to NUM_PORTS register channels.
// Independent write/read FSMs with port decode, DECERR on unmapped addresses and SLVERR on timeout.
module axil_reg_if_nport #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 16,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int NUM_PORTS       = 4,
    parameter int PORT_ADDR_WIDTH = 12,
    parameter int TIMEOUT         = 16
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic [ADDR_WIDTH-1:0]           s_axil_awaddr,
    input  logic [2:0]                      s_axil_awprot,
    input  logic                            s_axil_awvalid,
    output logic                            s_axil_awready,
    input  logic [DATA_WIDTH-1:0]           s_axil_wdata,
    input  logic [STRB_WIDTH-1:0]           s_axil_wstrb,
    input  logic                            s_axil_wvalid,
    output logic                            s_axil_wready,
    output logic [1:0]                      s_axil_bresp,
    output logic                            s_axil_bvalid,
    input  logic                            s_axil_bready,

    input  logic [ADDR_WIDTH-1:0]           s_axil_araddr,
    input  logic [2:0]                      s_axil_arprot,
    input  logic                            s_axil_arvalid,
    output logic                            s_axil_arready,
    output logic [DATA_WIDTH-1:0]           s_axil_rdata,
    output logic [1:0]                      s_axil_rresp,
    output logic                            s_axil_rvalid,
    input  logic                            s_axil_rready,

    output logic [PORT_ADDR_WIDTH-1:0]      reg_wr_addr,
    output logic [DATA_WIDTH-1:0]           reg_wr_data,
    output logic [STRB_WIDTH-1:0]           reg_wr_strb,
    output logic [NUM_PORTS-1:0]            reg_wr_en,
    input  logic [NUM_PORTS-1:0]            reg_wr_wait,
    input  logic [NUM_PORTS-1:0]            reg_wr_ack,
    output logic [PORT_ADDR_WIDTH-1:0]      reg_rd_addr,
    output logic [NUM_PORTS-1:0]            reg_rd_en,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] reg_rd_data,
    input  logic [NUM_PORTS-1:0]            reg_rd_wait,
    input  logic [NUM_PORTS-1:0]            reg_rd_ack
);

    localparam int SELW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNTW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int DECW = PORT_ADDR_WIDTH + SELW;

    localparam logic [SELW:0]   PORT_LIMIT = (SELW + 1)'(NUM_PORTS);
    localparam logic [CNTW-1:0] TMO_LAST   = CNTW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

    function automatic logic addr_mapped(input logic [ADDR_WIDTH-1:0] a);
        logic [SELW:0] sel;
        sel = {1'b0, a[PORT_ADDR_WIDTH +: SELW]};
        return ((a >> DECW) == '0) && (sel < PORT_LIMIT);
    endfunction

    logic unused_prot;
    assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

    // ---------------- write path ----------------
    state_t          wr_state, wr_state_next;
    logic [SELW-1:0] wr_port;
    logic [CNTW-1:0] wr_cnt;
    logic            wr_accept, wr_ack_sel, wr_wait_sel, wr_timeout;

    assign wr_ack_sel  = reg_wr_ack[wr_port];
    assign wr_wait_sel = reg_wr_wait[wr_port];
    assign wr_timeout  = (TIMEOUT > 0) && !wr_ack_sel && !wr_wait_sel && (wr_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) wr_state <= ST_IDLE;
        else     wr_state <= wr_state_next;
    end

    always_comb begin
        wr_state_next = wr_state;
        wr_accept     = 1'b0;
        case (wr_state)
            ST_IDLE: begin
                if (s_axil_awvalid && s_axil_wvalid && !rst) begin
                    wr_accept     = 1'b1;
                    wr_state_next = addr_mapped(s_axil_awaddr) ? ST_ACCESS : ST_RESP;
                end
            end
            ST_ACCESS: if (wr_ack_sel || wr_timeout) wr_state_next = ST_RESP;
            ST_RESP:   if (s_axil_bready) wr_state_next = ST_IDLE;
            default:   wr_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_port      <= '0;
            wr_cnt       <= '0;
            s_axil_bresp <= RESP_OKAY;
            reg_wr_addr  <= '0;
            reg_wr_data  <= '0;
            reg_wr_strb  <= '0;
        end else begin
            case (wr_state)
                ST_IDLE: begin
                    if (wr_accept) begin
                        wr_port      <= s_axil_awaddr[PORT_ADDR_WIDTH +: SELW];
                        wr_cnt       <= '0;
                        reg_wr_addr  <= s_axil_awaddr[PORT_ADDR_WIDTH-1:0];
                        reg_wr_data  <= s_axil_wdata;
                        reg_wr_strb  <= s_axil_wstrb;
                        s_axil_bresp <= addr_mapped(s_axil_awaddr) ? RESP_OKAY : RESP_DECERR;
                    end
                end
                ST_ACCESS: begin
                    if (wr_ack_sel)       s_axil_bresp <= RESP_OKAY;
                    else if (wr_wait_sel) wr_cnt       <= '0;
                    else if (wr_timeout)  s_axil_bresp <= RESP_SLVERR;
                    else                  wr_cnt       <= wr_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign s_axil_awready = wr_accept;
    assign s_axil_wready  = wr_accept;
    assign s_axil_bvalid  = (wr_state == ST_RESP);
    assign reg_wr_en      = (wr_state == ST_ACCESS) ? (NUM_PORTS'(1) << wr_port) : '0;

    // ---------------- read path ----------------
    state_t                rd_state, rd_state_next;
    logic [SELW-1:0]       rd_port;
    logic [CNTW-1:0]       rd_cnt;
    logic                  rd_accept, rd_ack_sel, rd_wait_sel, rd_timeout;
    logic [DATA_WIDTH-1:0] rd_slice [NUM_PORTS];

    always_comb begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            rd_slice[i] = reg_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign rd_ack_sel  = reg_rd_ack[rd_port];
    assign rd_wait_sel = reg_rd_wait[rd_port];
    assign rd_timeout  = (TIMEOUT > 0) && !rd_ack_sel && !rd_wait_sel && (rd_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) rd_state <= ST_IDLE;
        else     rd_state <= rd_state_next;
    end

    always_comb begin
        rd_state_next = rd_state;
        rd_accept     = 1'b0;
        case (rd_state)
            ST_IDLE: begin
                if (s_axil_arvalid && !rst) begin
                    rd_accept     = 1'b1;
                    rd_state_next = addr_mapped(s_axil_araddr) ? ST_ACCESS : ST_RESP;
                end
            end
            ST_ACCESS: if (rd_ack_sel || rd_timeout) rd_state_next = ST_RESP;
            ST_RESP:   if (s_axil_rready) rd_state_next = ST_IDLE;
            default:   rd_state_next = ST_IDLE;
        endcase
    end

    // rdata is cleared on accept so DECERR and SLVERR responses both return zero
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_port      <= '0;
            rd_cnt       <= '0;
            s_axil_rresp <= RESP_OKAY;
            s_axil_rdata <= '0;
            reg_rd_addr  <= '0;
        end else begin
            case (rd_state)
                ST_IDLE: begin
                    if (rd_accept) begin
                        rd_port      <= s_axil_araddr[PORT_ADDR_WIDTH +: SELW];
                        rd_cnt       <= '0;
                        reg_rd_addr  <= s_axil_araddr[PORT_ADDR_WIDTH-1:0];
                        s_axil_rdata <= '0;
                        s_axil_rresp <= addr_mapped(s_axil_araddr) ? RESP_OKAY : RESP_DECERR;
                    end
                end
                ST_ACCESS: begin
                    if (rd_ack_sel) begin
                        s_axil_rresp <= RESP_OKAY;
                        s_axil_rdata <= rd_slice[rd_port];
                    end else if (rd_wait_sel) begin
                        rd_cnt <= '0;
                    end else if (rd_timeout) begin
                        s_axil_rresp <= RESP_SLVERR;
                        s_axil_rdata <= '0;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_axil_arready = rd_accept;
    assign s_axil_rvalid  = (rd_state == ST_RESP);
    assign reg_rd_en      = (rd_state == ST_ACCESS) ? (NUM_PORTS'(1) << rd_port) : '0;

endmodule

// File: tb/tb_axil_reg_if_nport.sv
// Scoreboard bench for axil_reg_if_nport: randomized AXI-Lite traffic and port responders,
// expected responses derived from a cycle-count model of ack/wait/timeout rules.
module tb_axil_reg_if_nport;
    localparam int DW = 32, AW = 16, SW = 4, NP = 4, PAW = 12, TMO = 16;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] awaddr, araddr;
    logic [2:0] awprot, arprot;
    logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic [1:0] bresp, rresp;
    logic [PAW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;
    logic [NP-1:0] wr_en, wr_wait, wr_ack, rd_en, rd_wait, rd_ack;
    logic [NP*DW-1:0] rd_data;

    axil_reg_if_nport #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .NUM_PORTS(NP),
                        .PORT_ADDR_WIDTH(PAW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .reg_wr_addr(wr_addr), .reg_wr_data(wr_data), .reg_wr_strb(wr_strb), .reg_wr_en(wr_en),
        .reg_wr_wait(wr_wait), .reg_wr_ack(wr_ack), .reg_rd_addr(rd_addr), .reg_rd_en(rd_en),
        .reg_rd_data(rd_data), .reg_rd_wait(rd_wait), .reg_rd_ack(rd_ack));

    // Three-port instance for decode of a non-power-of-two port count
    logic [AW-1:0] u3_awaddr, u3_araddr;
    logic u3_awvalid, u3_awready, u3_wready, u3_bvalid, u3_arvalid, u3_arready, u3_rvalid;
    logic [DW-1:0] u3_rdata, u3_wr_data;
    logic [1:0] u3_bresp, u3_rresp;
    logic [PAW-1:0] u3_wr_addr, u3_rd_addr;
    logic [SW-1:0] u3_wr_strb;
    logic [2:0] u3_wr_en, u3_rd_en, u3_zero3;
    logic [3*DW-1:0] u3_rd_data;
    logic u3_wr_seen;
    logic [2:0] u3_rd_seen;

    axil_reg_if_nport #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .NUM_PORTS(3),
                        .PORT_ADDR_WIDTH(PAW), .TIMEOUT(TMO)) dut3 (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(u3_awaddr), .s_axil_awprot(3'b000), .s_axil_awvalid(u3_awvalid), .s_axil_awready(u3_awready),
        .s_axil_wdata(32'h1111_2222), .s_axil_wstrb(4'hF), .s_axil_wvalid(u3_awvalid), .s_axil_wready(u3_wready),
        .s_axil_bresp(u3_bresp), .s_axil_bvalid(u3_bvalid), .s_axil_bready(1'b1),
        .s_axil_araddr(u3_araddr), .s_axil_arprot(3'b000), .s_axil_arvalid(u3_arvalid), .s_axil_arready(u3_arready),
        .s_axil_rdata(u3_rdata), .s_axil_rresp(u3_rresp), .s_axil_rvalid(u3_rvalid), .s_axil_rready(1'b1),
        .reg_wr_addr(u3_wr_addr), .reg_wr_data(u3_wr_data), .reg_wr_strb(u3_wr_strb), .reg_wr_en(u3_wr_en),
        .reg_wr_wait(u3_zero3), .reg_wr_ack(u3_zero3), .reg_rd_addr(u3_rd_addr), .reg_rd_en(u3_rd_en),
        .reg_rd_data(u3_rd_data), .reg_rd_wait(u3_zero3), .reg_rd_ack(u3_zero3));

    typedef struct {
        int port; logic [PAW-1:0] addr; logic [DW-1:0] data; logic [SW-1:0] strb;
        int ack_at; int wp; int len;
    } plan_t;
    typedef struct { logic [1:0] resp; logic [DW-1:0] data; int hs; int lat; } exp_t;

    plan_t wr_plan_q[$], rd_plan_q[$];
    exp_t  b_exp_q[$], r_exp_q[$];
    plan_t wr_cur, rd_cur;
    int n_cmp = 0, n_bad = 0, cyc = 0;
    int wc = 0, rc = 0;
    bit wr_abort = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
    endtask

    // A port times out after TMO consecutive enable cycles with neither ack nor wait
    function automatic void model(input int ack_at, input int wp, output logic ok, output int len);
        int since = 0;
        ok = 1'b0;
        len = 0;
        for (int c = 1; c <= 1000; c++) begin
            if (c == ack_at) begin ok = 1'b1; len = c; return; end
            if (wp != 0 && c % wp == 0) since = 0;
            else since++;
            if (since == TMO) begin len = c; return; end
        end
    endfunction

    function automatic plan_t mk_plan(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                      input logic [SW-1:0] s, input int ack_at, input int wp);
        plan_t p;
        logic ok;
        p.port = int'(a[PAW +: 2]);
        p.addr = a[PAW-1:0];
        p.data = d;
        p.strb = s;
        p.ack_at = ack_at;
        p.wp = wp;
        model(ack_at, wp, ok, p.len);
        return p;
    endfunction

    function automatic exp_t mk_exp(input logic [AW-1:0] a, input plan_t p, input int hs);
        exp_t e;
        logic ok;
        int len;
        model(p.ack_at, p.wp, ok, len);
        e.hs = hs;
        if (a[AW-1:PAW+2] != 0) begin
            e.resp = 2'b11; e.data = '0; e.lat = 1;
        end else begin
            e.resp = ok ? 2'b00 : 2'b10; e.data = ok ? p.data : '0; e.lat = len + 1;
        end
        return e;
    endfunction

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                            input int ack_at, input int wp);
        plan_t p;
        int t;
        p = mk_plan(a, d, s, ack_at, wp);
        @(negedge clk);
        if ($urandom % 4 == 0) begin
            awvalid = 1'b1; awaddr = a; wvalid = 1'b0;
            repeat (2) begin #1 check("aw_without_w_ready", {awready, wready}, 0); @(negedge clk); end
        end
        awvalid = 1'b1; wvalid = 1'b1; awaddr = a; wdata = d; wstrb = s; awprot = 3'($urandom);
        t = 0;
        #1;
        while (!awready && t < 2000) begin @(negedge clk); #1; t++; end
        if (!awready) begin
            fail_now("aw_handshake_wait");
        end else begin
            check("awready_wready_pair", wready, 1);
            if (a[AW-1:PAW+2] == 0) wr_plan_q.push_back(p);
            b_exp_q.push_back(mk_exp(a, p, cyc));
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input int ack_at, input int wp);
        plan_t p;
        int t;
        p = mk_plan(a, d, '0, ack_at, wp);
        @(negedge clk);
        arvalid = 1'b1; araddr = a; arprot = 3'($urandom);
        t = 0;
        #1;
        while (!arready && t < 2000) begin @(negedge clk); #1; t++; end
        if (!arready) begin
            fail_now("ar_handshake_wait");
        end else begin
            if (a[AW-1:PAW+2] == 0) rd_plan_q.push_back(p);
            r_exp_q.push_back(mk_exp(a, p, cyc));
        end
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic rand_txn(output logic [AW-1:0] a, output int ack_at, output int wp);
        int k;
        a = {(($urandom % 7 == 0) ? 2'($urandom_range(1, 3)) : 2'b00), 2'($urandom), 12'($urandom)};
        k = $urandom % 6;
        wp = 0;
        case (k)
            0: ack_at = 1;
            1: ack_at = $urandom_range(2, 10);
            2: ack_at = $urandom_range(12, 20);
            3: ack_at = 0;
            4: begin ack_at = 40; wp = 10; end
            default: begin ack_at = $urandom_range(20, 40); wp = $urandom_range(5, 20); end
        endcase
    endtask

    // Write-port responder: one plan per enable burst, other ports' ack/wait kept random
    logic [NP-1:0] w_ack_v, w_wait_v, r_ack_v, r_wait_v;
    logic [NP*DW-1:0] r_data_v;
    always @(negedge clk) begin
        w_ack_v = NP'($urandom);
        w_wait_v = NP'($urandom);
        if (wr_en != 0) begin
            if (wc == 0) begin
                if (wr_plan_q.size() == 0) begin
                    fail_now("wr_en_unexpected");
                    wr_cur = '{port: 0, addr: '0, data: '0, strb: '0, ack_at: 1, wp: 0, len: 1};
                end else begin
                    wr_cur = wr_plan_q.pop_front();
                    check("wr_en_onehot", wr_en, NP'(1) << wr_cur.port);
                    check("wr_fields", {wr_addr, wr_strb, wr_data}, {wr_cur.addr, wr_cur.strb, wr_cur.data});
                end
            end
            wc++;
            w_ack_v[wr_cur.port] = (wc == wr_cur.ack_at);
            w_wait_v[wr_cur.port] = (wr_cur.wp != 0) && (wc % wr_cur.wp == 0);
        end else if (wc != 0) begin
            if (wr_abort) wr_abort = 0;
            else check("wr_en_cycles", wc, wr_cur.len);
            wc = 0;
        end
        wr_ack = w_ack_v;
        wr_wait = w_wait_v;
    end

    always @(negedge clk) begin
        r_ack_v = NP'($urandom);
        r_wait_v = NP'($urandom);
        for (int i = 0; i < NP; i++) r_data_v[i*DW +: DW] = $urandom;
        if (rd_en != 0) begin
            if (rc == 0) begin
                if (rd_plan_q.size() == 0) begin
                    fail_now("rd_en_unexpected");
                    rd_cur = '{port: 0, addr: '0, data: '0, strb: '0, ack_at: 1, wp: 0, len: 1};
                end else begin
                    rd_cur = rd_plan_q.pop_front();
                    check("rd_en_onehot", rd_en, NP'(1) << rd_cur.port);
                    check("rd_addr", rd_addr, rd_cur.addr);
                end
            end
            rc++;
            r_ack_v[rd_cur.port] = (rc == rd_cur.ack_at);
            r_wait_v[rd_cur.port] = (rd_cur.wp != 0) && (rc % rd_cur.wp == 0);
            if (rc == rd_cur.ack_at) r_data_v[rd_cur.port*DW +: DW] = rd_cur.data;
        end else if (rc != 0) begin
            check("rd_en_cycles", rc, rd_cur.len);
            rc = 0;
        end
        rd_ack = r_ack_v;
        rd_wait = r_wait_v;
        rd_data = r_data_v;
    end

    // Response monitors: random backpressure, stability while stalled, latency from handshake
    bit b_busy = 0, b_stable = 0, r_busy = 0, r_stable = 0;
    int b_hold = 0, b_first = 0, r_hold = 0, r_first = 0;
    logic [1:0] b_cap;
    logic [DW+1:0] r_cap;
    exp_t be, re;
    always @(negedge clk) begin
        if (rst) begin
            bready = 1'b0; b_busy = 0;
        end else if (bready) begin
            bready = 1'b0;
        end else if (bvalid) begin
            if (!b_busy) begin
                b_busy = 1; b_hold = $urandom % 6; b_cap = bresp; b_first = cyc; b_stable = 1;
            end else if (bresp !== b_cap) b_stable = 0;
            if (b_hold == 0) begin
                if (b_exp_q.size() == 0) fail_now("bvalid_unexpected");
                else begin
                    be = b_exp_q.pop_front();
                    check("bresp", bresp, be.resp);
                    check("b_latency", b_first - be.hs, be.lat);
                    check("b_stable_stalled", b_stable, 1);
                end
                bready = 1'b1; b_busy = 0;
            end else b_hold--;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            rready = 1'b0; r_busy = 0;
        end else if (rready) begin
            rready = 1'b0;
        end else if (rvalid) begin
            if (!r_busy) begin
                r_busy = 1; r_hold = $urandom % 6; r_cap = {rresp, rdata}; r_first = cyc; r_stable = 1;
            end else if ({rresp, rdata} !== r_cap) r_stable = 0;
            if (r_hold == 0) begin
                if (r_exp_q.size() == 0) fail_now("rvalid_unexpected");
                else begin
                    re = r_exp_q.pop_front();
                    check("rresp_rdata", {rresp, rdata}, {re.resp, re.data});
                    check("r_latency", r_first - re.hs, re.lat);
                    check("r_stable_stalled", r_stable, 1);
                end
                rready = 1'b1; r_busy = 0;
            end else r_hold--;
        end
    end

    always @(negedge clk) begin
        if (u3_wr_en != 0) u3_wr_seen = 1'b1;
        u3_rd_seen = u3_rd_seen | u3_rd_en;
    end

    task automatic drain();
        int t = 0;
        while ((b_exp_q.size() != 0 || r_exp_q.size() != 0 || wc != 0 || rc != 0) && t < 3000) begin
            @(negedge clk); t++;
        end
        if (t >= 3000) fail_now("drain_responses");
    endtask

    task automatic u3_wait(input string name, input bit is_rd);
        int t = 0;
        while (!(is_rd ? u3_rvalid : u3_bvalid) && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) fail_now(name);
    endtask

    initial begin
        logic [AW-1:0] a;
        int ack_at, wp;
        awaddr = '0; awprot = '0; wdata = '0; wstrb = '0; araddr = '0; arprot = '0;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        u3_awaddr = '0; u3_araddr = '0; u3_awvalid = 1'b0; u3_arvalid = 1'b0; u3_zero3 = '0;
        u3_rd_data = '0; u3_wr_seen = 1'b0; u3_rd_seen = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_readies", {awready, wready, arready}, 0);
        check("rst_valids", {bvalid, rvalid}, 0);
        check("rst_resp_rdata", {bresp, rresp, rdata}, 0);
        check("rst_enables", {wr_en, rd_en}, 0);
        check("rst_reg_fields", {wr_addr, rd_addr, wr_strb, wr_data}, 0);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        rst = 1'b0;

        fork
            begin
                do_write(16'h1004, 32'hA5A5_0001, 4'hF, 1, 0);
                do_write(16'h0008, 32'h0BAD_F00D, 4'h5, 6, 0);
                do_write(16'h2010, 32'h1357_9BDF, 4'hF, 0, 0);
                do_write(16'hC000, 32'h2468_ACE0, 4'hF, 1, 0);
                repeat (40) begin
                    rand_txn(a, ack_at, wp);
                    do_write(a, $urandom, 4'($urandom), ack_at, wp);
                end
            end
            begin
                do_read(16'h3010, 32'hDEAD_BEEF, 3, 0);
                do_read(16'h0020, 32'h5555_AAAA, 0, 0);
                do_read(16'h0024, 32'h0F0F_1234, 40, 10);
                do_read(16'h2000, 32'h7777_8888, 4, 0);
                do_read(16'h8000, 32'h9999_0000, 1, 0);
                repeat (40) begin
                    rand_txn(a, ack_at, wp);
                    do_read(a, $urandom, ack_at, wp);
                end
            end
        join
        drain();

        // Reset while a write enable is active: no response, next write completes normally
        do_write(16'h0040, 32'h1234_5678, 4'h3, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_mid_en_active", wr_en, 4'b0001);
        wr_abort = 1;
        void'(b_exp_q.pop_back());
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_en_low", wr_en, 0);
        check("rst_mid_bvalid_low", bvalid, 0);
        rst = 1'b0;
        do_write(16'h0044, 32'hCAFE_0001, 4'hF, 2, 0);
        drain();

        // Three-port instance: port index 3 and high address bits are unmapped
        @(negedge clk);
        u3_wr_seen = 1'b0; u3_rd_seen = '0;
        u3_awaddr = 16'h3000; u3_awvalid = 1'b1;
        @(negedge clk);
        u3_awvalid = 1'b0;
        u3_wait("np3_bvalid_wait", 0);
        check("np3_bresp_decerr", u3_bresp, 2'b11);
        @(negedge clk);
        check("np3_no_wr_en", u3_wr_seen, 0);
        u3_araddr = 16'h8000; u3_arvalid = 1'b1;
        @(negedge clk);
        u3_arvalid = 1'b0;
        u3_wait("np3_rvalid_wait", 1);
        check("np3_rresp_decerr", {u3_rresp, u3_rdata}, {2'b11, 32'h0});
        @(negedge clk);
        u3_araddr = 16'h2004; u3_arvalid = 1'b1;
        @(negedge clk);
        u3_arvalid = 1'b0;
        repeat (TMO) @(negedge clk);
        u3_wait("np3_slverr_wait", 1);
        check("np3_rresp_slverr", {u3_rresp, u3_rdata}, {2'b10, 32'h0});
        check("np3_rd_en_port2", u3_rd_seen, 3'b100);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end
endmodule
